// File: rtl/rv32i_gcd_host.sv
// rv32i_gcd_host: host-side sequencer that hands an operand pair to an RV32I GCD program
// and returns the value the core writes back to RESULT_REG, or a timeout response.
module rv32i_gcd_host #(
    parameter logic [4:0]  RESULT_REG     = 5'd10,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_timeout,
    output logic        calc_start,
    output logic [31:0] gcd_a,
    output logic [31:0] gcd_b,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] gcd_a_q, gcd_a_d;
    logic [31:0] gcd_b_q, gcd_b_d;
    logic [31:0] result_q, result_d;
    logic        timeout_q, timeout_d;
    logic        hit, expire;

    assign hit    = wb_we && (wb_addr == RESULT_REG);
    assign expire = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcd_a_d   = gcd_a_q;
        gcd_b_d   = gcd_b_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (req_valid) begin
                gcd_a_d = req_a;
                gcd_b_d = req_b;
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = 32'd0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 32'd1;
                // a write-back landing on the timeout edge still counts as a real result
                if (hit) begin
                    result_d  = wb_data;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (expire) begin
                    result_d  = 32'd0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            gcd_a_q   <= 32'd0;
            gcd_b_q   <= 32'd0;
            result_q  <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcd_a_q   <= gcd_a_d;
            gcd_b_q   <= gcd_b_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready    = state_q == IDLE;
    assign calc_start   = state_q == RUN;
    assign resp_valid   = state_q == RESP;
    assign busy         = state_q != IDLE;
    assign gcd_a        = gcd_a_q;
    assign gcd_b        = gcd_b_q;
    assign resp_result  = result_q;
    assign resp_timeout = timeout_q;

endmodule

// File: tb/tb_rv32i_gcd_host.sv
// tb_rv32i_gcd_host: directed scenarios with a response scoreboard popped by a monitor.
module tb_rv32i_gcd_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_result;
    logic        resp_timeout;
    logic        calc_start;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        busy;

    typedef struct {
        logic [31:0] r;
        logic        t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    rv32i_gcd_host #(.RESULT_REG(5'd10), .TIMEOUT_CYCLES(32'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_timeout(resp_timeout),
        .calc_start(calc_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got result %0d with nothing expected", resp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_result", resp_result, e.r);
                chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.t});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_calc_start"}, {31'd0, calc_start}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_timeout"}, {31'd0, resp_timeout}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_resp_result"}, resp_result, 32'd0);
        chk({tag, "_gcd_a"}, gcd_a, 32'd0);
        chk({tag, "_gcd_b"}, gcd_b, 32'd0);
    endtask

    // handshake, then one SETUP cycle, leaving the DUT just entered into RUN
    task automatic do_req(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        step();
        req_valid = 1'b0;
        req_a = 32'hdead_beef;
        req_b = 32'hcafe_f00d;
        chk("setup_calc_start", {31'd0, calc_start}, 32'd0);
        chk("setup_req_ready", {31'd0, req_ready}, 32'd0);
        chk("setup_busy", {31'd0, busy}, 32'd1);
        chk("gcd_a", gcd_a, a);
        chk("gcd_b", gcd_b, b);
        step();
        chk("run_calc_start", {31'd0, calc_start}, 32'd1);
        chk("run_gcd_a_hold", gcd_a, a);
        chk("run_gcd_b_hold", gcd_b, b);
    endtask

    task automatic hit(input logic [31:0] d);
        exp_t e;
        e.r = d;
        e.t = 1'b0;
        exp_q.push_back(e);
        wb_we = 1'b1;
        wb_addr = 5'd10;
        wb_data = d;
        step();
        wb_we = 1'b0;
        wb_addr = 5'd0;
        chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("hit_calc_start", {31'd0, calc_start}, 32'd0);
        chk("hit_result", resp_result, d);
    endtask

    initial begin
        exp_t e;
        #2;
        check_reset_vals("por");
        step();
        rst_n = 1'b1;
        step();

        // basic: a=48 b=18, hit three cycles into RUN
        do_req(32'd48, 32'd18);
        step();
        step();
        hit(32'd6);
        chk("basic_timeout", {31'd0, resp_timeout}, 32'd0);
        step();
        chk("basic_back_idle", {31'd0, req_ready}, 32'd1);

        // backpressure: response held for 5 cycles, a pending request is stalled
        resp_ready = 1'b0;
        do_req(32'd48, 32'd18);
        step();
        hit(32'd6);
        req_valid = 1'b1;
        req_a = 32'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_result", resp_result, 32'd6);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_gcd_a_hold", gcd_a, 32'd48);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        chk("bp_back_idle", {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b0;

        // timeout after exactly 8 RUN cycles
        do_req(32'd100, 32'd75);
        e.r = 32'd0;
        e.t = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_not_yet", {31'd0, resp_valid}, 32'd0);
        end
        step();
        chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("to_flag", {31'd0, resp_timeout}, 32'd1);
        chk("to_result", resp_result, 32'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // hit on the same edge as the timeout wins
        do_req(32'd15, 32'd10);
        for (int i = 0; i < 7; i++) step();
        hit(32'd5);
        chk("tie_timeout", {31'd0, resp_timeout}, 32'd0);
        resp_ready = 1'b1;
        step();

        // filtering: RESULT_REG writes in IDLE/SETUP and other indices in RUN are ignored
        wb_we = 1'b1;
        wb_addr = 5'd10;
        wb_data = 32'd99;
        step();
        chk("flt_idle_busy", {31'd0, busy}, 32'd0);
        chk("flt_idle_resp", {31'd0, resp_valid}, 32'd0);
        do_req(32'd0, 32'd0);
        chk("flt_setup_resp", {31'd0, resp_valid}, 32'd0);
        wb_addr = 5'd11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flt_run_resp", {31'd0, resp_valid}, 32'd0);
            chk("flt_run_calc", {31'd0, calc_start}, 32'd1);
        end
        wb_we = 1'b0;
        hit(32'd3);
        step();

        // reset mid-RUN aborts with no response, then a fresh request completes
        do_req(32'd1, 32'd2);
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        step();
        rst_n = 1'b1;
        check_reset_vals("rst_held");
        step();
        chk("rst_idle", {31'd0, req_ready}, 32'd1);
        do_req(32'd7, 32'd21);
        step();
        hit(32'd7);
        step();
        step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
